// File: rtl/mbist_op_sel_pkg.sv
// rtl/mbist_op_sel_pkg.sv - shared MBIST stimulus format, op-slot type and sequencer states
package mbist_op_sel_pkg;

   localparam int BIST_OP_SIZE   = 5;
   localparam int BIST_STI_WD    = 3*BIST_OP_SIZE+1;
   localparam int OP_SLOT_WD     = 3;
   localparam int SLOT_VALID_BIT = 2;
   localparam int SLOT_RW_BIT    = 1;
   localparam int SLOT_INV_BIT   = 0;

   // {valid, rw, inv} slot encodings
   localparam logic [OP_SLOT_WD-1:0] BIST_STIMULUS_TYPE_NONE = 3'b000;
   localparam logic [OP_SLOT_WD-1:0] BIST_STIMULUS_TYPE_R0   = 3'b100;
   localparam logic [OP_SLOT_WD-1:0] BIST_STIMULUS_TYPE_R1   = 3'b101;
   localparam logic [OP_SLOT_WD-1:0] BIST_STIMULUS_TYPE_W0   = 3'b110;
   localparam logic [OP_SLOT_WD-1:0] BIST_STIMULUS_TYPE_W1   = 3'b111;

   typedef struct packed {
      logic valid;
      logic rw;
      logic inv;
   } op_slot_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } op_state_t;

endpackage

// File: rtl/mbist_op_sel.sv
// rtl/mbist_op_sel.sv - MBIST operation sequencer: walks op slots of the current march element
module mbist_op_sel
   import mbist_op_sel_pkg::*;
#(
   parameter int BIST_OP_SIZE = mbist_op_sel_pkg::BIST_OP_SIZE,
   parameter int BIST_STI_WD  = 3*BIST_OP_SIZE+1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   bist_en,
   input  logic [BIST_STI_WD-1:0] stimulus,
   input  logic                   last_stimulus,
   input  logic                   last_addr,
   input  logic                   op_hold,
   output logic                   op_read,
   output logic                   op_write,
   output logic                   op_invert,
   output logic                   addr_down,
   output logic                   op_updp,
   output logic                   sti_run,
   output logic                   bist_done
);

   localparam int PTR_W = $clog2(BIST_OP_SIZE);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BIST_OP_SIZE-1);

   op_state_t         state, state_nxt;
   logic [PTR_W-1:0]  ptr, ptr_nxt;
   op_slot_t          slots [BIST_OP_SIZE];
   logic [BIST_OP_SIZE-1:0] nxt_valid;
   op_slot_t          cur;
   logic              issue, slot_last, empty;

   // slots[] is in execution order: index 0 is the MSB slot of the word
   for (genvar i = 0; i < BIST_OP_SIZE; i++) begin : g_slot
      assign slots[i] = op_slot_t'(stimulus[OP_SLOT_WD*(BIST_OP_SIZE-1-i) +: OP_SLOT_WD]);
      if (i < BIST_OP_SIZE-1) begin : g_nv
         assign nxt_valid[i] = stimulus[OP_SLOT_WD*(BIST_OP_SIZE-2-i) + SLOT_VALID_BIT];
      end else begin : g_nv_end
         assign nxt_valid[i] = 1'b0;
      end
   end

   assign cur       = slots[ptr];
   assign slot_last = (ptr == PTR_LAST) || !nxt_valid[ptr];
   assign issue     = (state == ST_EXEC) && !op_hold;
   // An invalid slot can only be seen at ptr 0, i.e. an empty element
   assign empty     = !cur.valid;
   assign addr_down = stimulus[BIST_STI_WD-1];
   assign bist_done = (state == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      op_read   = issue && cur.valid && !cur.rw;
      op_write  = issue && cur.valid && cur.rw;
      op_invert = issue && cur.valid && cur.inv;
      op_updp   = issue && cur.valid && slot_last;
      sti_run   = (issue && cur.valid && slot_last && last_addr) || (issue && empty);
      case (state)
         ST_IDLE: begin
            ptr_nxt = '0;
            if (bist_en) state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            if (issue) begin
               ptr_nxt = (op_updp || sti_run) ? '0 : ptr + 1'b1;
               if (sti_run && last_stimulus && last_addr) state_nxt = ST_DONE;
            end
         end
         ST_DONE: ptr_nxt = '0;
         default: begin
            state_nxt = ST_IDLE;
            ptr_nxt   = '0;
         end
      endcase
      if (!bist_en) begin
         state_nxt = ST_IDLE;
         ptr_nxt   = '0;
      end
   end

endmodule

// File: tb/tb_mbist_op_sel.sv
// tb/tb_mbist_op_sel.sv - randomized walks of mbist_op_sel against an op-list reference model
module tb_mbist_op_sel;
   localparam int OPS = 5;
   localparam int WD  = 3*OPS+1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          bist_en = 1'b0;
   logic [WD-1:0] stimulus = '0;
   logic          last_stimulus = 1'b0;
   logic          last_addr = 1'b0;
   logic          op_hold = 1'b0;
   logic          op_read, op_write, op_invert, addr_down, op_updp, sti_run, bist_done;

   int total = 0;
   int bad = 0;

   typedef struct {
      bit rd; bit wr; bit inv; bit updp; bit run;
      int sidx; int aidx;
   } exp_t;

   exp_t          q[$];
   logic [WD-1:0] words [4];

   mbist_op_sel #(.BIST_OP_SIZE(OPS), .BIST_STI_WD(WD)) dut (
      .clk(clk), .rst_n(rst_n), .bist_en(bist_en), .stimulus(stimulus),
      .last_stimulus(last_stimulus), .last_addr(last_addr), .op_hold(op_hold),
      .op_read(op_read), .op_write(op_write), .op_invert(op_invert),
      .addr_down(addr_down), .op_updp(op_updp), .sti_run(sti_run), .bist_done(bist_done)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] obs();
      return {op_read, op_write, op_invert, op_updp, sti_run, bist_done, addr_down};
   endfunction

   task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got rd/wr/inv/updp/run/done/down=%b required %b", tag, got, exp);
      end
   endtask

   // Op list j (0 = first executed) placed into slot OPS-1-j as {1, rw, inv}
   function automatic logic [WD-1:0] mk_word(input bit down, input int n,
                                             input bit [OPS-1:0] rw, input bit [OPS-1:0] inv);
      logic [WD-1:0] w;
      w = '0;
      w[WD-1] = down;
      for (int j = 0; j < n; j++) w[3*(OPS-1-j) +: 3] = {1'b1, rw[j], inv[j]};
      return w;
   endfunction

   task automatic run_walk(input int tno);
      int n_sti, n_addr, cycles;
      int nops [4];
      bit [OPS-1:0] rw [4];
      bit [OPS-1:0] iv [4];
      bit hold;
      exp_t e;
      n_sti  = $urandom_range(1, 4);
      n_addr = $urandom_range(1, 4);
      q.delete();
      for (int s = 0; s < n_sti; s++) begin
         nops[s] = (s == n_sti-1) ? $urandom_range(1, OPS) : $urandom_range(0, OPS);
         rw[s]   = OPS'($urandom);
         iv[s]   = OPS'($urandom);
         words[s] = mk_word(1'($urandom), nops[s], rw[s], iv[s]);
         if (nops[s] == 0)
            q.push_back('{0, 0, 0, 0, 1, s, 0});
         else
            for (int a = 0; a < n_addr; a++)
               for (int j = 0; j < nops[s]; j++)
                  q.push_back('{!rw[s][j], rw[s][j], iv[s][j], j == nops[s]-1,
                                (j == nops[s]-1) && (a == n_addr-1), s, a});
      end
      @(negedge clk);
      bist_en = 1'b1;
      cycles = 0;
      while (q.size() > 0 && cycles < 2000) begin
         @(negedge clk);
         e = q[0];
         hold = ($urandom_range(0, 3) == 0);
         op_hold       = hold;
         stimulus      = words[e.sidx];
         last_addr     = (e.aidx == n_addr-1);
         last_stimulus = (e.sidx == n_sti-1);
         #2;
         if (hold)
            chk($sformatf("walk%0d_hold", tno), obs(), {6'b0, words[e.sidx][WD-1]});
         else
            chk($sformatf("walk%0d_op", tno), obs(),
                {e.rd, e.wr, e.inv, e.updp, e.run, 1'b0, words[e.sidx][WD-1]});
         @(posedge clk);
         if (!hold) void'(q.pop_front());
         cycles++;
      end
      if (q.size() > 0) chk($sformatf("walk%0d_timeout", tno), 7'd1, 7'd0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         op_hold = 1'($urandom);
         #2;
         chk($sformatf("walk%0d_done", tno), obs(), {5'b0, 1'b1, stimulus[WD-1]});
      end
      bist_en = 1'b0;
      op_hold = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #2;
      chk($sformatf("walk%0d_clear", tno), obs(), {6'b0, stimulus[WD-1]});
   endtask

   initial begin
      stimulus = mk_word(1'b0, 2, 5'b00010, 5'b00010);
      #3;
      chk("reset", obs(), 7'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #2;
      chk("idle", obs(), 7'b0);

      // Abort at ptr 2 of {R0, W1, R1}, then restart at the first slot
      stimulus = mk_word(1'b1, 3, 5'b00010, 5'b00110);
      last_addr = 1'b0;
      last_stimulus = 1'b0;
      bist_en = 1'b1;
      @(negedge clk); #2;
      chk("abort_op0", obs(), 7'b1000001);
      @(negedge clk); #2;
      chk("abort_op1", obs(), 7'b0110001);
      @(negedge clk); #2;
      chk("abort_op2", obs(), 7'b1011001);
      bist_en = 1'b0;
      @(negedge clk); #2;
      chk("abort_idle", obs(), 7'b0000001);
      bist_en = 1'b1;
      @(negedge clk); #2;
      chk("abort_restart", obs(), 7'b1000001);
      bist_en = 1'b0;
      @(negedge clk);

      for (int t = 0; t < 30; t++) run_walk(t);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mbist_op_sel.md
# mbist_op_sel

MBIST operation sequencer: consumes the one-hot-selected march stimulus word and issues the per-address read/write operations it encodes, stepping the address generator and the stimulus selector. It sits between the stimulus selector, which it drives through that block's `run` input, and the address generator / memory interface. A walk completes when the last stimulus finishes at the last address.

## Interface
Parameters:
- BIST_OP_SIZE, 5, op slots per stimulus word
- BIST_STI_WD, 3*BIST_OP_SIZE+1 (16), stimulus width; must equal the package constant

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- bist_en  in  1  start/enable; deassert aborts
- stimulus  in  BIST_STI_WD  current march element from stimulus selector
- last_stimulus  in  1  current stimulus is final one
- last_addr  in  1  address generator at final address for current direction
- op_hold  in  1  stall from compare/memory side
- op_read  out  1  issue read this cycle
- op_write  out  1  issue write this cycle
- op_invert  out  1  data background inverted for issued op
- addr_down  out  1  address direction for current stimulus (1 = descending)
- op_updp  out  1  pulse: advance address after this op
- sti_run  out  1  pulse: advance stimulus selector (its `run`)
- bist_done  out  1  walk complete, sticky until bist_en low

## Operation
- Stimulus format: bit [BIST_STI_WD-1] = down; slot i at bits [3i+2:3i] = {valid, rw (1 = write), inv}; slot BIST_OP_SIZE-1 (MSB) executes first; valid slots packed from MSB, first invalid slot ends the element.
- FSM: IDLE, EXEC, DONE.
  - IDLE -> EXEC when bist_en=1.
  - EXEC -> DONE on issue of a stimulus end with last_addr=1 and last_stimulus=1.
  - Any state -> IDLE when bist_en=0 (abort, next edge); DONE holds until then.
- Op pointer ptr (log2 width) indexes the slot, 0 = MSB slot. Reset to 0 in IDLE and on every op_updp.
- issue = (state==EXEC) & !op_hold.
- op_read/op_write/op_invert are combinational from slot[ptr] gated by issue; op_read = valid & !rw, op_write = valid & rw.
- slot_last = ptr==BIST_OP_SIZE-1 or next slot invalid.
- op_updp = issue & slot[ptr].valid & slot_last; else issue increments ptr.
- sti_run = op_updp & last_addr.
- Empty stimulus (MSB slot invalid): one issue cycle with no read/write and no op_updp; sti_run pulses anyway (element skipped).
- addr_down = stimulus MSB, combinational, all states.
- op_hold freezes state and ptr; all pulses and ops read 0 while held.

## Timing
- Reset: state IDLE, ptr 0; op_read, op_write, op_invert, op_updp, sti_run, bist_done = 0.
- bist_en sampled high at edge N -> first op issued cycle N (after edge), no extra latency.
- One op per unheld cycle; stimulus of k ops over A addresses = k*A cycles plus hold cycles.
- sti_run and last op of the final address coincide. The selector rotates on the same edge, so the new stimulus is valid the next cycle with ptr=0.
- bist_done rises the cycle after the final sti_run; no ops issue in DONE.
- bist_en low mid-walk: at next edge, IDLE and outputs 0; re-enable restarts at ptr 0. The selector/address generator are reset by their owners.
- op_hold and a final op in the same cycle: nothing issues; retried next unheld cycle.

## Structure
- Slot field offsets, BIST_OP_SIZE, BIST_STI_WD and the BIST_STIMULUS_TYPE* encodings belong in the shared MBIST package/def header. Add an op-slot struct typedef {valid, rw, inv} and the FSM state enum.
- No sub-module; single flat block (FSM + ptr counter + slot decode).

## Test plan
- Stimulus {down=0, W0} (slot4=3'b110), last_addr high on 4th op -> 4 op_write cycles with inv=0, 4 op_updp pulses, sti_run with 4th.
- Stimulus {R0,W1} (slot4=3'b100, slot3=3'b111), 2 addresses -> sequence R,W(inv),R,W(inv); op_updp on cycles 2 and 4 only.
- op_hold high 3 cycles mid-element -> ops/pulses 0 during hold, ptr unchanged, sequence resumes identically.
- Empty stimulus (all slots 0) -> one cycle, no read/write/op_updp, sti_run=1.
- Final stimulus, last_addr=1, last_stimulus=1 -> sti_run pulse, bist_done=1 next cycle, stays until bist_en=0, then 0.
- bist_en dropped mid-element at ptr=2 -> outputs 0 next cycle, state IDLE; re-enable issues slot 4 op first.
